// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - codec sample capture FIFO with data-driven filter triggering
// Optional build macro SAMPLE_FEEDER_MIX_EN: push the L/R average instead of the selected channel.
module sample_feeder #(
  parameter int W          = 24,
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 8191
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ready,
  input  logic [W-1:0]          l_in,
  input  logic [W-1:0]          r_in,
  input  logic                  chan_sel,
  input  logic                  filter_done,
  output logic [W-1:0]          data_out,
  output logic                  sample_trig,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  busy,
  output logic                  overflow,
  output logic                  timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [W-1:0]          data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic [W-1:0]          mem_q [DEPTH];

  logic                  push, pop, full, push_ok, cnt_hit;
  logic [W-1:0]          push_data;

`ifdef SAMPLE_FEEDER_MIX_EN
  logic signed [W:0] mix_sum;
  logic              sel_unused;
  assign mix_sum    = $signed({l_in[W-1], l_in}) + $signed({r_in[W-1], r_in});
  assign push_data  = W'(mix_sum >>> 1);
  assign sel_unused = chan_sel;
`else
  assign push_data = chan_sel ? r_in : l_in;
`endif

  assign push    = ready & ~ready_q;
  assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign pop     = (state_q == IDLE) && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push on full is still accepted.
  assign push_ok = push && (!full || pop);
  // Comparing the incremented value ends the wait after exactly TIMEOUT cycles.
  assign cnt_hit = ((cnt_q + CW'(1)) == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (filter_done || cnt_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_trig = (state_q == ISSUE);
    busy        = (state_q != IDLE);
  end

  always_comb begin
    ready_d    = ready;
    wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push_ok);
    rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    data_d     = pop ? mem_q[rd_ptr_q] : data_q;
    cnt_d      = cnt_q;
    if (state_q == ISSUE)
      cnt_d = '0;
    else if (state_q == WAIT_DONE && !filter_done && !cnt_hit)
      cnt_d = cnt_q + CW'(1);
    overflow_d = overflow_q | (push & full & ~pop);
    // Done wins over a coincident timeout.
    timeout_d  = timeout_q | ((state_q == WAIT_DONE) & ~filter_done & cnt_hit);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign data_out   = data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/sample_feeder.md
Name: sample_feeder

Overview:
Upstream feeder for notch_top.
- Captures one audio sample per codec frame from the Audio_Codec_Wrapper outputs (L_bus_out/R_bus_out, qualified by ready).
- Buffers samples in a small FIFO.
- Issues each sample to the filter with a one-cycle sample_trig pulse, then waits for the filter's done strobe.
- Replaces the free-running 5000-cycle trigger counter with data-driven triggering; adds overflow and timeout status.

Parameters:
W, 24, sample width (two's complement)
DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries (default 8)
TIMEOUT, 8191, max cycles in WAIT_DONE before abandoning a sample

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising clk
ready  input  1  codec ready level; rising edge marks new L/R sample
l_in  input  W  left channel sample (L_bus_out)
r_in  input  W  right channel sample (R_bus_out)
chan_sel  input  1  0 = left, 1 = right (ignored when mix feature compiled in)
filter_done  input  1  one-cycle pulse from filter: current sample finished
data_out  output  W  sample presented to filter; held stable until next issue
sample_trig  output  1  one-cycle pulse; data_out valid and new
fifo_count  output  DEPTH_LOG2+1  current FIFO occupancy
busy  output  1  high in ISSUE and WAIT_DONE
overflow  output  1  sticky: a push was dropped on full FIFO
timeout  output  1  sticky: a WAIT_DONE exceeded TIMEOUT

Behaviour:
- Reset (reset_n=0 at clk edge):
  - data_out=0, sample_trig=0, fifo_count=0, busy=0, overflow=0, timeout=0.
  - FIFO pointers=0, ready_q=0, state=IDLE, timeout counter=0.
  - Reset mid-operation discards FIFO contents and any in-flight sample. A filter_done arriving after reset is ignored, because the state is IDLE.
- Edge detect:
  - ready_q is ready registered.
  - push = ready & ~ready_q, evaluated in cycle t.
  - Write data is latched at the end of cycle t; fifo_count updates in t+1.
- Push data: chan_sel ? r_in : l_in (see optional feature).
- FIFO: circular buffer, wr/rd pointers DEPTH_LOG2 bits, wrap at 2^DEPTH_LOG2.
  - Full, push without pop: sample dropped, overflow<=1, count unchanged.
  - Full, push with pop in same cycle: both occur, count unchanged, no overflow.
  - Empty: no pop is issued.
- FSM:
  - IDLE: if fifo_count!=0, pop head into data_out and go to ISSUE. Min latency from ready edge (cycle t) to sample_trig high is cycle t+2.
  - ISSUE: sample_trig=1 for exactly this cycle; go to WAIT_DONE; clear timeout counter. filter_done in ISSUE is ignored.
  - WAIT_DONE:
    - filter_done=1 -> IDLE.
    - Else counter increments; when counter==TIMEOUT, set timeout<=1 and go to IDLE.
    - Simultaneous filter_done and counter==TIMEOUT: treat as done, timeout not set.
- data_out changes only on the IDLE->ISSUE transition.
- Back-to-back: after done, next trig no earlier than 2 cycles later (IDLE, ISSUE).
- overflow/timeout clear only on reset.

Optional Feature:
SAMPLE_FEEDER_MIX_EN
- Defined: push data = (sext(l_in)+sext(r_in)) >>> 1, computed in W+1 bits with arithmetic shift, truncated to W; chan_sel unused.
- Undefined: channel select as above.

Test Plan:
- Reset then single sample: l_in=24'h000123, chan_sel=0, ready 0->1 at cycle 10 -> sample_trig pulse at cycle 12, data_out=24'h000123, fifo_count 1 then 0, busy=1; filter_done at 20 -> busy=0 at 21.
- Fill and overflow: hold filter_done=0 (TIMEOUT large), 10 ready edges with distinct values -> first popped to data_out, 8 buffered, fifo_count=8, 10th dropped, overflow=1; then done pulses drain in order, with no values lost except the 10th.
- Timeout: TIMEOUT=16, one sample, no filter_done -> timeout=1 exactly 16 cycles after WAIT_DONE entry; state returns IDLE; next buffered sample issued.
- Push+pop on full: FIFO full, ready edge in the same cycle the FSM pops -> fifo_count stays 8, overflow stays 0.
- Reset mid-WAIT_DONE with 3 queued: reset_n low one cycle -> all outputs 0; late filter_done has no effect; no sample_trig until new ready edge.
- Mix (SAMPLE_FEEDER_MIX_EN): l_in=24'h7FFFFF, r_in=24'h7FFFFF -> data_out=24'h7FFFFF; l_in=24'h800000, r_in=24'h000000 -> data_out=24'hC00000.
